// File: rtl/lake_pkg.sv
// Shared constants for the memory-mapped UART transmitter: register offsets,
// STATUS bit positions and the serialiser state encoding.
// No logic, no latency, no flow control.
package lake_pkg;

  // Byte offsets inside the 8-byte UART window (decoded on address bit 2).
  localparam logic [2:0] UART_TXDATA_OFF = 3'd0;
  localparam logic [2:0] UART_STATUS_OFF = 3'd4;

  // STATUS register bit positions.
  localparam int ST_EMPTY = 0;
  localparam int ST_FULL  = 1;
  localparam int ST_BUSY  = 2;
  localparam int ST_OVF   = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_tx_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous first-word-fall-through FIFO, DEPTH a power of two.
// Latency: a push on edge N is visible on o_dout/o_empty after edge N.
// Backpressure: a push while full is accepted only when a pop happens on the same edge.
// Ports: i_clk/i_rst (async active-low), i_push/i_din write side,
//        i_pop read side, o_dout head entry, o_empty/o_full occupancy flags.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_din,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_dout,
  output logic             o_empty,
  output logic             o_full
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic [AW:0]      cnt;
  logic             do_pop;
  logic             do_push;

  assign o_empty = (cnt == '0);
  assign o_full  = (cnt == FULL_CNT);
  assign o_dout  = mem[rptr];

  // When full, the slot being written is the one being read this cycle, so
  // the head is consumed before it is overwritten.
  assign do_pop  = i_pop & ~o_empty;
  assign do_push = i_push & (~o_full | do_pop);

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else begin
      if (do_push) wptr <= wptr + AW'(1);
      if (do_pop)  rptr <= rptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + (AW + 1)'(1);
        2'b01:   cnt <= cnt - (AW + 1)'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (do_push) mem[wptr] <= i_din;
  end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: TXDATA pushes into a FIFO, STATUS reports state.
// Latency: store on edge N, FIFO pop on N+1, start bit on o_tx after N+1; frames are 10*CLKS_PER_BIT.
// Backpressure: none toward the core; a store to a full FIFO is dropped and sets sticky overflow.
// Ports: i_clk, i_rst (async active-low), i_addr/i_w_data/i_w_en store path,
//        o_sel/o_r_data load mux, o_tx serial line (idle high), o_busy activity flag.
module mmio_uart_tx
  import lake_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR    = 32'h1000_0000,
  parameter int          CLKS_PER_BIT = 868,
  parameter int          FIFO_DEPTH   = 16
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_w_data,
  input  logic        i_w_en,
  output logic        o_sel,
  output logic [31:0] o_r_data,
  output logic        o_tx,
  output logic        o_busy
);

  localparam int BW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BW-1:0] BCNT_MAX = BW'(CLKS_PER_BIT - 1);

  uart_tx_state_t state_q, state_d;
  logic [BW-1:0]  bcnt_q, bcnt_d;
  logic [2:0]     idx_q, idx_d;
  logic [7:0]     sh_q, sh_d;
  logic           tx_q, tx_d;
  logic           ovf_q;

  logic           is_txdata;
  logic           is_status;
  logic           push_req;
  logic           clr_ovf;
  logic           pop;
  logic [7:0]     fifo_dout;
  logic           fifo_empty;
  logic           fifo_full;
  logic [31:0]    status;
  logic           unused_bits;

  assign unused_bits = ^{i_addr[1:0], i_w_data[31:8]};

  // Address decode
  assign o_sel     = (i_addr[31:3] == BASE_ADDR[31:3]);
  assign is_txdata = (i_addr[2] == UART_TXDATA_OFF[2]);
  assign is_status = (i_addr[2] == UART_STATUS_OFF[2]);
  assign push_req  = i_w_en & o_sel & is_txdata;
  assign clr_ovf   = i_w_en & o_sel & is_status & i_w_data[3];

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_push  (push_req),
    .i_din   (i_w_data[7:0]),
    .i_pop   (pop),
    .o_dout  (fifo_dout),
    .o_empty (fifo_empty),
    .o_full  (fifo_full)
  );

  always_comb begin
    status            = '0;
    status[ST_EMPTY]  = fifo_empty;
    status[ST_FULL]   = fifo_full;
    status[ST_BUSY]   = (state_q != IDLE);
    status[ST_OVF]    = ovf_q;
    o_r_data          = (o_sel && is_status) ? status : '0;
  end

  assign o_busy = ~fifo_empty | (state_q != IDLE);
  assign o_tx   = tx_q;

  // Serialiser next-state. The line level is computed for the state being
  // entered so that o_tx can come straight from a flop.
  always_comb begin
    state_d = state_q;
    bcnt_d  = bcnt_q;
    idx_d   = idx_q;
    sh_d    = sh_q;
    pop     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          sh_d    = fifo_dout;
          bcnt_d  = BCNT_MAX;
          state_d = START;
        end
      end
      START: begin
        if (bcnt_q == '0) begin
          bcnt_d  = BCNT_MAX;
          idx_d   = 3'd0;
          state_d = DATA;
        end else begin
          bcnt_d = bcnt_q - BW'(1);
        end
      end
      DATA: begin
        if (bcnt_q == '0) begin
          sh_d   = {1'b0, sh_q[7:1]};
          bcnt_d = BCNT_MAX;
          if (idx_q == 3'd7) state_d = STOP;
          else               idx_d   = idx_q + 3'd1;
        end else begin
          bcnt_d = bcnt_q - BW'(1);
        end
      end
      STOP: begin
        if (bcnt_q == '0) begin
          // Chain straight into the next start bit when more data is queued.
          if (!fifo_empty) begin
            pop     = 1'b1;
            sh_d    = fifo_dout;
            bcnt_d  = BCNT_MAX;
            state_d = START;
          end else begin
            state_d = IDLE;
          end
        end else begin
          bcnt_d = bcnt_q - BW'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    unique case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = sh_d[0];
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q <= IDLE;
      bcnt_q  <= '0;
      idx_q   <= '0;
      sh_q    <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      bcnt_q  <= bcnt_d;
      idx_q   <= idx_d;
      sh_q    <= sh_d;
      tx_q    <= tx_d;
    end
  end

  // Sticky overflow: a dropped push beats a clear on the same edge.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst)                             ovf_q <= 1'b0;
    else if (push_req & fifo_full & ~pop)   ovf_q <= 1'b1;
    else if (clr_ovf)                       ovf_q <= 1'b0;
  end

endmodule

// File: tb/tb_mmio_uart_tx.sv
module tb_mmio_uart_tx;

  localparam logic [31:0] BASE  = 32'h1000_0000;
  localparam int          CPB   = 4;
  localparam int          DEPTH = 4;
  localparam int          FRAME = 10 * CPB;

  logic        clk;
  logic        rst_n;
  logic [31:0] addr;
  logic [31:0] w_data;
  logic        w_en;
  logic        sel;
  logic [31:0] rdata;
  logic        tx;
  logic        busy;

  int checks;
  int failures;

  mmio_uart_tx #(
    .BASE_ADDR    (BASE),
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .i_clk    (clk),
    .i_rst    (rst_n),
    .i_addr   (addr),
    .i_w_data (w_data),
    .i_w_en   (w_en),
    .o_sel    (sel),
    .o_r_data (rdata),
    .o_tx     (tx),
    .o_busy   (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- behavioural reference model ----------------
  // Transmitter is a frame-time countdown: tx_rem cycles left in the frame
  // currently on the line (0 = idle). Queue holds accepted, unsent bytes.
  logic [7:0] byte_q[$];
  int         tx_rem;
  logic [7:0] cur_byte;
  bit         ovf_m;

  function automatic void model_reset();
    byte_q.delete();
    tx_rem   = 0;
    cur_byte = 8'h00;
    ovf_m    = 1'b0;
  endfunction

  function automatic bit in_win(logic [31:0] a);
    return (a >= BASE) && (a < BASE + 32'd8);
  endfunction

  function automatic void model_edge(bit push_req, logic [7:0] d, bit clr);
    int pre_size = byte_q.size();
    bit popped = 1'b0;
    bit set_ovf = 1'b0;
    if (tx_rem <= 1) begin
      if (pre_size > 0) begin
        popped   = 1'b1;
        cur_byte = byte_q.pop_front();
        tx_rem   = FRAME;
      end else begin
        tx_rem = 0;
      end
    end else begin
      tx_rem = tx_rem - 1;
    end
    if (push_req) begin
      if (pre_size < DEPTH || popped) byte_q.push_back(d);
      else set_ovf = 1'b1;
    end
    if (set_ovf)  ovf_m = 1'b1;
    else if (clr) ovf_m = 1'b0;
  endfunction

  function automatic logic exp_tx();
    int p;
    if (tx_rem == 0) return 1'b1;
    p = (FRAME - tx_rem) / CPB;
    if (p == 0) return 1'b0;
    if (p == 9) return 1'b1;
    return cur_byte[p-1];
  endfunction

  function automatic logic [31:0] exp_status();
    logic [31:0] s = '0;
    s[0] = (byte_q.size() == 0);
    s[1] = (byte_q.size() == DEPTH);
    s[2] = (tx_rem != 0);
    s[3] = ovf_m;
    return s;
  endfunction

  function automatic logic [31:0] exp_rdata(logic [31:0] a);
    if (!in_win(a)) return 32'h0;
    return ((a - BASE) >= 32'd4) ? exp_status() : 32'h0;
  endfunction

  // ---------------- checking helpers ----------------
  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic check_rd();
    #1;
    check("sel", {31'b0, sel}, {31'b0, in_win(addr)});
    check("rdata", rdata, exp_rdata(addr));
  endtask

  // One clock edge: model advances with the inputs held across the edge,
  // then line and busy are compared 1 time unit after the edge.
  task automatic tick();
    bit pr;
    bit cl;
    pr = w_en && in_win(addr) && ((addr - BASE) < 32'd4);
    cl = w_en && in_win(addr) && ((addr - BASE) >= 32'd4) && w_data[3];
    @(posedge clk);
    if (!rst_n) model_reset();
    else        model_edge(pr, w_data[7:0], cl);
    #1;
    check("tx_model", {31'b0, tx}, {31'b0, exp_tx()});
    check("busy_model", {31'b0, busy},
          {31'b0, (byte_q.size() != 0) || (tx_rem != 0)});
  endtask

  task automatic store(logic [31:0] a, logic [31:0] d);
    addr   = a;
    w_data = d;
    w_en   = 1'b1;
    tick();
    w_en   = 1'b0;
    addr   = BASE + 32'd4;
  endtask

  typedef struct {
    logic [31:0] a;
    logic        exp_sel;
    logic [31:0] exp_rd;
  } rd_vec_t;

  rd_vec_t vecs[7];
  logic    samp[90];

  initial begin
    checks   = 0;
    failures = 0;

    vecs[0] = '{BASE + 32'd4, 1'b1, 32'h1};
    vecs[1] = '{BASE + 32'd0, 1'b1, 32'h0};
    vecs[2] = '{BASE + 32'd8, 1'b0, 32'h0};
    vecs[3] = '{BASE + 32'd7, 1'b1, 32'h1};
    vecs[4] = '{BASE + 32'd3, 1'b1, 32'h0};
    vecs[5] = '{BASE - 32'd4, 1'b0, 32'h0};
    vecs[6] = '{32'h2000_0004, 1'b0, 32'h0};

    rst_n  = 1'b0;
    w_en   = 1'b0;
    addr   = BASE + 32'd4;
    w_data = 32'h0;
    model_reset();
    repeat (3) tick();
    rst_n = 1'b1;

    // Reset-state register reads
    for (int i = 0; i < 7; i++) begin
      addr = vecs[i].a;
      #1;
      check($sformatf("rd_vec%0d_sel", i), {31'b0, sel}, {31'b0, vecs[i].exp_sel});
      check($sformatf("rd_vec%0d_data", i), rdata, vecs[i].exp_rd);
    end
    check("reset_tx", {31'b0, tx}, 32'h1);
    check("reset_busy", {31'b0, busy}, 32'h0);

    // Single frame 0x55
    store(BASE, 32'h55);
    check("tx_high_after_push", {31'b0, tx}, 32'h1);
    for (int k = 0; k < FRAME; k++) begin
      tick();
      check($sformatf("f55_s%0d", k), {31'b0, tx}, {31'b0, logic'((k / CPB) % 2)});
    end
    tick();
    check("busy_after_frame", {31'b0, busy}, 32'h0);

    // Back-to-back frames 0xA3, 0x0F
    begin
      logic [7:0] b1;
      logic [7:0] b2;
      b1 = 8'hA3;
      b2 = 8'h0F;
      store(BASE, {24'h0, b1});
      store(BASE, {24'h0, b2});
      samp[0] = tx;
      for (int k = 1; k <= 2 * FRAME; k++) begin
        tick();
        samp[k] = tx;
      end
      for (int k = 0; k < CPB; k++) begin
        check("b2b_stop1", {31'b0, samp[FRAME - CPB + k]}, 32'h1);
        check("b2b_start2", {31'b0, samp[FRAME + k]}, 32'h0);
      end
      for (int i = 0; i < 8; i++) begin
        check($sformatf("b2b_a3_bit%0d", i), {31'b0, samp[(1 + i) * CPB + 2]}, {31'b0, b1[i]});
        check($sformatf("b2b_0f_bit%0d", i), {31'b0, samp[FRAME + (1 + i) * CPB + 2]}, {31'b0, b2[i]});
      end
      check("b2b_idle_after", {31'b0, samp[2 * FRAME]}, 32'h1);
    end

    // Burst of 6 into depth-4 FIFO from idle
    for (int i = 0; i < 6; i++) begin
      addr   = BASE;
      w_data = 32'h30 + i;
      w_en   = 1'b1;
      tick();
    end
    w_en = 1'b0;
    addr = BASE + 32'd4;
    #1;
    check("burst_status", rdata, 32'hE);
    store(BASE + 32'd4, 32'h8);
    #1;
    check("ovf_clear_status", rdata, 32'h6);
    check_rd();
    repeat (5 * FRAME + 4) tick();
    check("burst_drained_busy", {31'b0, busy}, 32'h0);

    // Asynchronous reset mid-DATA with 3 bytes queued
    for (int i = 0; i < 4; i++) store(BASE, 32'hC0 + i);
    repeat (8) tick();
    check("pre_rst_busy", {31'b0, busy}, 32'h1);
    rst_n = 1'b0;
    model_reset();
    #1;
    check("rst_tx_immediate", {31'b0, tx}, 32'h1);
    tick();
    rst_n = 1'b1;
    addr  = BASE + 32'd4;
    #1;
    check("rst_status", rdata, 32'h1);
    begin
      int lows = 0;
      for (int k = 0; k < 60; k++) begin
        tick();
        if (tx !== 1'b1) lows++;
      end
      check("rst_no_frames", lows, 32'h0);
    end

    // STATUS write of 0xFF with empty FIFO pushes nothing
    store(BASE + 32'd4, 32'hFF);
    #1;
    check("status_ff_write", rdata, 32'h1);
    repeat (10) tick();
    check("status_ff_tx", {31'b0, tx}, 32'h1);

    // Randomised traffic against the model
    for (int c = 0; c < 1500; c++) begin
      int r;
      r = $urandom_range(0, 99);
      w_en = 1'b0;
      if (r < 6) begin
        addr   = BASE + $urandom_range(0, 3);
        w_data = $urandom;
        w_en   = 1'b1;
      end else if (r < 9) begin
        addr   = BASE + 32'd4 + $urandom_range(0, 3);
        w_data = $urandom;
        w_en   = 1'b1;
      end else if (r < 13) begin
        addr   = (r[0]) ? BASE + 32'd8 + $urandom_range(0, 400) : BASE - 32'd1 - $urandom_range(0, 400);
        w_data = $urandom;
        w_en   = 1'b1;
      end else begin
        addr   = BASE + $urandom_range(0, 15);
        w_data = $urandom;
      end
      check_rd();
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
